wb_regfile: RTL and testbench

//   Write-back stage and architectural register file of the 5-stage MIPS pipeline.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile_core.sv | 65 ++++++
 rtl/wb_regfile.sv | 75 +++++++
 tb/tb_wb_regfile.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back control field layout and
// default datapath widths.
package mips_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int CNT_W_DEF     = 32;

  // Bit positions inside the 2-bit wb_ctrl field from the MEM/WB register
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam int REG_ZERO      = 0;

  typedef enum logic [1:0] {
    WB_BUBBLE   = 2'b00,
    WB_NOP_LOAD = 2'b01,
    WB_ALU      = 2'b10,
    WB_LOAD     = 2'b11
  } wb_ctrl_e;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / register-read bundle between the pipeline (master) and the
// write-back stage with its register file (slave).
interface wb_regfile_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [1:0]        wb_ctrl;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_alu_res;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output wb_ctrl, wb_rd, wb_mem_data, wb_alu_res, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_commit, retire_cnt
  );

  modport slave (
    input  wb_ctrl, wb_rd, wb_mem_data, wb_alu_res, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_commit, retire_cnt
  );

endinterface

// File: rtl/wb_regfile_core.sv
// 2-read/1-write architectural register array with hardwired zero register
// and optional same-cycle write-to-read bypass.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic              wr_en_s;

  assign wr_en_s = we && (waddr != ADDR_W'(REG_ZERO));

  // Register storage: async clear, writes to the zero register are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end else begin
      regs_r[waddr] <= regs_r[waddr];
    end
  end

  // Port A read mux: zero register wins over the bypass path
  always_comb begin
    rdata_a = regs_r[raddr_a];
    if (raddr_a == ADDR_W'(REG_ZERO)) begin
      rdata_a = '0;
    end else if ((BYPASS != 0) && wr_en_s && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_r[raddr_a];
    end
  end

  // Port B read mux, identical rules to port A
  always_comb begin
    rdata_b = regs_r[raddr_b];
    if (raddr_b == ADDR_W'(REG_ZERO)) begin
      rdata_b = '0;
    end else if ((BYPASS != 0) && wr_en_s && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_r[raddr_b];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects the write-back value, commits it to the
// register file and counts retired register writes.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] wb_data_s;
  logic              commit_s;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  // Write-back source select: load data or ALU result
  always_comb begin
    wb_data_s = bus.wb_alu_res;
    if (bus.wb_ctrl[WB_MEM_TO_REG]) begin
      wb_data_s = bus.wb_mem_data;
    end else begin
      wb_data_s = bus.wb_alu_res;
    end
  end

  // A bubble or a write aimed at $zero never counts as a commit
  always_comb begin
    commit_s = 1'b0;
    if (bus.wb_ctrl[WB_REG_WRITE] && (bus.wb_rd != ADDR_W'(REG_ZERO))) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Retired-write counter, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= '0;
    end else if (commit_s) begin
      retire_cnt_r <= retire_cnt_r + CNT_W'(1);
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_s),
    .waddr   (bus.wb_rd),
    .wdata   (wb_data_s),
    .raddr_a (bus.rs_addr),
    .raddr_b (bus.rt_addr),
    .rdata_a (rs_data_s),
    .rdata_b (rt_data_s)
  );

  assign bus.wb_data    = wb_data_s;
  assign bus.wb_commit  = commit_s;
  assign bus.retire_cnt = retire_cnt_r;
  assign bus.rs_data    = rs_data_s;
  assign bus.rt_data    = rt_data_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: two instances (bypass/32-bit counter and
// no-bypass/4-bit counter) driven identically and compared to an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] mem;
  logic [31:0] alu;
  logic        chk_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus_a ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_b ();

  assign bus_a.wb_ctrl = ctrl;  assign bus_b.wb_ctrl = ctrl;
  assign bus_a.wb_rd = rd;      assign bus_b.wb_rd = rd;
  assign bus_a.wb_mem_data = mem; assign bus_b.wb_mem_data = mem;
  assign bus_a.wb_alu_res = alu;  assign bus_b.wb_alu_res = alu;
  assign bus_a.rs_addr = rs;    assign bus_b.rs_addr = rs;
  assign bus_a.rt_addr = rt;    assign bus_b.rt_addr = rt;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_wb();
    return ctrl[0] ? mem : alu;
  endfunction

  function automatic logic exp_commit();
    return ctrl[1] && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && exp_commit() && (a == rd)) return exp_wb();
    return m_regs[a];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: array of registers plus a plain integer retire count
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_cnt <= 32'd0;
    end else if (exp_commit()) begin
      m_regs[rd] <= exp_wb();
      m_cnt      <= m_cnt + 32'd1;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("a.wb_data",    bus_a.wb_data, exp_wb());
      check("a.wb_commit",  {31'd0, bus_a.wb_commit}, {31'd0, exp_commit()});
      check("a.rs_data",    bus_a.rs_data, exp_read(rs, 1'b1));
      check("a.rt_data",    bus_a.rt_data, exp_read(rt, 1'b1));
      check("a.retire_cnt", bus_a.retire_cnt, m_cnt);
      check("b.wb_data",    bus_b.wb_data, exp_wb());
      check("b.wb_commit",  {31'd0, bus_b.wb_commit}, {31'd0, exp_commit()});
      check("b.rs_data",    bus_b.rs_data, exp_read(rs, 1'b0));
      check("b.rt_data",    bus_b.rt_data, exp_read(rt, 1'b0));
      check("b.retire_cnt", {28'd0, bus_b.retire_cnt}, {28'd0, m_cnt[3:0]});
    end
  end

  task automatic drive(input logic [1:0] c, input logic [4:0] d, input logic [31:0] m,
                       input logic [31:0] a, input logic [4:0] s, input logic [4:0] t);
    @(posedge clk);
    #1;
    ctrl = c; rd = d; mem = m; alu = a; rs = s; rt = t;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b0;
    ctrl = 2'b00; rd = 5'd0; mem = 32'd0; alu = 32'd0; rs = 5'd0; rt = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Load every register, then reset mid-cycle
    for (int i = 1; i < 32; i++) drive(2'b10, 5'(i), $urandom, $urandom, 5'(i), 5'(i - 1));
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31);
    pulse_rst();
    @(negedge clk);
    check("rst.a.rs", bus_a.rs_data, 32'd0);
    check("rst.b.rt", bus_b.rt_data, 32'd0);
    check("rst.a.cnt", bus_a.retire_cnt, 32'd0);

    // Write from ALU result
    drive(2'b10, 5'd5, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0, 5'd0);
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);
    @(negedge clk);
    check("alu.a.rs", bus_a.rs_data, 32'h0000_1234);
    check("alu.a.cnt", bus_a.retire_cnt, 32'd1);

    // Write from memory
    drive(2'b11, 5'd7, 32'hDEAD_BEEF, 32'h0000_0100, 5'd7, 5'd7);
    @(negedge clk);
    check("mem.a.wb_data", bus_a.wb_data, 32'hDEAD_BEEF);
    check("mem.b.rs_old", bus_b.rs_data, 32'd0);
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7);
    @(negedge clk);
    check("mem.b.rt", bus_b.rt_data, 32'hDEAD_BEEF);

    // Bypass on both ports at once
    drive(2'b10, 5'd9, 32'd0, 32'h0000_CAFE, 5'd9, 5'd9);
    @(negedge clk);
    check("byp.a.rs", bus_a.rs_data, 32'h0000_CAFE);
    check("byp.a.rt", bus_a.rt_data, 32'h0000_CAFE);
    check("byp.b.rs", bus_b.rs_data, 32'd0);
    check("byp.b.rt", bus_b.rt_data, 32'd0);

    // Zero register
    drive(2'b11, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("zero.commit", {31'd0, bus_a.wb_commit}, 32'd0);
    check("zero.a.rs", bus_a.rs_data, 32'd0);
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd9);
    @(negedge clk);
    check("zero.a.cnt", bus_a.retire_cnt, 32'd3);
    check("zero.b.rt", bus_b.rt_data, 32'h0000_CAFE);

    // No-write cycles, then counter wrap on the 4-bit instance
    repeat (3) drive(2'b01, 5'($urandom_range(1, 31)), $urandom, $urandom, 5'd9, 5'd7);
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd9, 5'd7);
    @(negedge clk);
    check("nowr.a.cnt", bus_a.retire_cnt, 32'd3);
    check("nowr.a.rt", bus_a.rt_data, 32'hDEAD_BEEF);
    pulse_rst();
    for (int i = 0; i < 16; i++) drive(2'b10, 5'(1 + (i % 31)), $urandom, $urandom, 5'd0, 5'd0);
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("wrap.b.cnt", {28'd0, bus_b.retire_cnt}, 32'd0);
    check("wrap.a.cnt", bus_a.retire_cnt, 32'd16);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r_rd;
      r_rd = 5'($urandom_range(0, 31));
      drive(2'($urandom), r_rd, $urandom, $urandom,
            ($urandom_range(0, 1) == 0) ? r_rd : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom));
      if ($urandom_range(0, 199) == 0) pulse_rst();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
